// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state
// encoding and the sizing helper for the no-ack watchdog counter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_TIMEOUT = 2'd2
    } arb_state_t;

    // Bits needed to count from 0 up to timeout_cycles inclusive; a disabled
    // watchdog (0) still gets a one-bit counter so the declaration stays legal.
    function automatic int wdog_width(input int timeout_cycles);
        if (timeout_cycles < 1) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer, scanning upward and wrapping from NUM_MASTERS-1 back to 0.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]       idx_o
);

    int   cand;
    logic found;

    // Walk the requesters in priority order starting at the pointer; the
    // first hit wins and later hits are masked by the found flag.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one granted master per cyc tenure is muxed
// onto the shared slave, ack/err are steered back to it alone, and a watchdog
// ends tenures whose slave never answers a strobe.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     wb_clk_i,
    input  logic                                     wb_rst_i,
    input  logic [NUM_MASTERS-1:0]                   m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                   m_stb_i,
    input  logic [NUM_MASTERS-1:0]                   m_we_i,
    input  logic [NUM_MASTERS*(BUS_DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]    m_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]                   m_ack_o,
    output logic [NUM_MASTERS-1:0]                   m_err_o,
    output logic                                     s_cyc_o,
    output logic                                     s_stb_o,
    output logic                                     s_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0]              s_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]                s_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]                s_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                     s_ack_i,
    input  logic                                     s_err_i,
    output logic [NUM_MASTERS-1:0]                   grant_o
);

    localparam int BYTE_ENABLES = BUS_DATA_WIDTH / 8;
    localparam int IDX_W        = $clog2(NUM_MASTERS);
    localparam int WD_W         = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(TIMEOUT_CYCLES);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       ptr_after;
    logic [WD_W:0]          wdog_inc;
    logic                   g_cyc, g_stb, busy, tmo;

    assign req       = m_cyc_i & m_stb_i;
    assign g_cyc     = m_cyc_i[gidx_q];
    assign g_stb     = m_stb_i[gidx_q];
    assign busy      = (state_q == ARB_BUSY);
    assign tmo       = (state_q == ARB_TIMEOUT);
    assign wdog_inc  = {1'b0, wdog_q} + 1'b1;
    assign ptr_after = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Next-state logic: grant from IDLE, release on cyc low, watchdog count.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        wdog_d  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!g_cyc) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                end else if (g_stb && !s_ack_i && !s_err_i && (TIMEOUT_CYCLES != 0)) begin
                    if (wdog_inc == WD_LIMIT) begin
                        state_d = ARB_TIMEOUT;
                    end else begin
                        wdog_d = wdog_inc[WD_W-1:0];
                    end
                end
            end
            ARB_TIMEOUT: begin
                if (!g_cyc) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; the asynchronous clear drops every output at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    // Slave-side mux: only a BUSY tenure reaches the slave.
    always_comb begin
        s_cyc_o = busy & g_cyc;
        s_stb_o = busy & g_stb;
        s_we_o  = busy & m_we_i[gidx_q];
        s_sel_o = busy ? m_sel_i[gidx_q*BYTE_ENABLES +: BYTE_ENABLES] : '0;
        s_adr_o = busy ? m_adr_i[gidx_q*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH] : '0;
        s_dat_o = busy ? m_dat_i[gidx_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
        m_dat_o = (busy || tmo) ? s_dat_i : '0;
    end

    // Master-side steering: ack/err reach the granted master only; in TIMEOUT
    // the error level follows that master's strobe, like a held slave ack.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
            assign m_ack_o[gi] = busy & grant_q[gi] & s_ack_i;
            assign m_err_o[gi] = grant_q[gi] & ((busy & s_err_i) | (tmo & m_stb_i[gi]));
        end
    endgenerate

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter (4 masters, 32-bit data, 8-bit address,
// watchdog of 4 cycles): vector table, directed corner cases and a random
// phase, all checked against a tenure-level reference model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BE = DW / 8;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*BE-1:0] m_sel_i = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0;
    logic [DW-1:0]   m_dat_o, s_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [BE-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 busy, 2 timed out
    int mst = 0, mg = 0, mptr = 0, mcnt = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS (N), .BUS_DATA_WIDTH (DW), .BUS_ADDR_WIDTH (AW), .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .m_cyc_i (m_cyc_i), .m_stb_i (m_stb_i), .m_we_i (m_we_i),
        .m_sel_i (m_sel_i), .m_adr_i (m_adr_i), .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_sel_o (s_sel_o), .s_adr_o (s_adr_o), .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        logic [3:0]  cyc, stb, we;
        logic [7:0]  a0;  logic [31:0] d0; logic [3:0] s0;
        logic [7:0]  a1;  logic [31:0] d1; logic [3:0] s1;
        logic        s_ack; logic [31:0] s_dat;
        logic [3:0]  e_grant; logic e_cyc, e_stb; logic [7:0] e_adr;
        logic [31:0] e_wdat; logic [3:0] e_sel, e_ack; logic [31:0] e_rdat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mst = 0; mg = 0; mptr = 0; mcnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        logic [N-1:0] req;
        bit found;
        req = m_cyc_i & m_stb_i;
        if (rst) begin
            model_reset();
        end else if (mst == 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(mptr + k) % N]) begin
                    found = 1;
                    mg = (mptr + k) % N;
                end
            end
            if (found) begin
                mst = 1; mcnt = 0;
            end
        end else if (!m_cyc_i[mg]) begin
            mst = 0; mptr = (mg + 1) % N; mcnt = 0;
        end else if (mst == 1) begin
            if (m_stb_i[mg] && !s_ack_i && !s_err_i) begin
                mcnt++;
                if (mcnt == TO) begin
                    mst = 2; mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    endtask

    // Compare every DUT output against what the model says the bus should show.
    task automatic model_check();
        bit bsy, held;
        logic [N-1:0] one;
        bsy  = (mst == 1);
        held = (mst != 0);
        one  = N'(1) << mg;
        chk("mdl_grant", grant_o, held ? one : '0);
        chk("mdl_s_cyc", s_cyc_o, bsy ? m_cyc_i[mg] : 1'b0);
        chk("mdl_s_stb", s_stb_o, bsy ? m_stb_i[mg] : 1'b0);
        chk("mdl_s_we",  s_we_o,  bsy ? m_we_i[mg]  : 1'b0);
        chk("mdl_s_sel", s_sel_o, bsy ? m_sel_i[mg*BE +: BE] : '0);
        chk("mdl_s_adr", s_adr_o, bsy ? m_adr_i[mg*AW +: AW] : '0);
        chk("mdl_s_dat", s_dat_o, bsy ? m_dat_i[mg*DW +: DW] : '0);
        chk("mdl_ack",   m_ack_o, (bsy && s_ack_i) ? one : '0);
        chk("mdl_err",   m_err_o, ((bsy && s_err_i) || (mst == 2 && m_stb_i[mg])) ? one : '0);
        chk("mdl_rdat",  m_dat_o, held ? s_dat_i : '0);
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        @(posedge clk); #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, hi, w;
        logic [N-1:0] seen;

        // Single master, pointer move, release timing (rows 0-9);
        // two-master write contention from reset (rows 10-16).
        vecs[0]  = '{1, 4'h1, 4'h1, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[1]  = '{0, 4'h1, 4'h1, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 1, 32'hDEAD0001, 4'h1, 1, 1, 8'h00, 32'h0, 4'hF, 4'h1, 32'hDEAD0001};
        vecs[2]  = '{0, 4'h0, 4'h0, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h1, 0, 0, 8'h00, 32'h0, 4'hF, 4'h0, 32'h0};
        vecs[3]  = '{0, 4'h0, 4'h0, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[4]  = '{0, 4'h3, 4'h3, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[5]  = '{0, 4'h3, 4'h3, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h2, 1, 1, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[6]  = '{0, 4'h1, 4'h1, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h2, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[7]  = '{0, 4'h1, 4'h1, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[8]  = '{0, 4'h0, 4'h0, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h1, 0, 0, 8'h00, 32'h0, 4'hF, 4'h0, 32'h0};
        vecs[9]  = '{0, 4'h0, 4'h0, 4'h0, 8'h00, 32'h0, 4'hF, 8'h00, 32'h0, 4'h0, 0, 32'h0,        4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 4'h0, 32'h0};
        vecs[10] = '{1, 4'h3, 4'h3, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 0, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0,        4'h0, 4'h0, 32'h0};
        vecs[11] = '{0, 4'h3, 4'h3, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 1, 32'h0, 4'h1, 1, 1, 8'h04, 32'h11223344, 4'hF, 4'h1, 32'h0};
        vecs[12] = '{0, 4'h2, 4'h2, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 0, 32'h0, 4'h1, 0, 0, 8'h04, 32'h11223344, 4'hF, 4'h0, 32'h0};
        vecs[13] = '{0, 4'h2, 4'h2, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 0, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0,        4'h0, 4'h0, 32'h0};
        vecs[14] = '{0, 4'h2, 4'h2, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 1, 32'h0, 4'h2, 1, 1, 8'h05, 32'h55667788, 4'h3, 4'h2, 32'h0};
        vecs[15] = '{0, 4'h0, 4'h0, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 0, 32'h0, 4'h2, 0, 0, 8'h05, 32'h55667788, 4'h3, 4'h0, 32'h0};
        vecs[16] = '{0, 4'h0, 4'h0, 4'h3, 8'h04, 32'h11223344, 4'hF, 8'h05, 32'h55667788, 4'h3, 0, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0,        4'h0, 4'h0, 32'h0};

        // Outputs are quiet while reset is held from time zero
        #2;
        chk("reset_grant", grant_o, '0);
        chk("reset_s_cyc", s_cyc_o, 1'b0);
        chk("reset_ack",   m_ack_o, '0);
        chk("reset_rdat",  m_dat_o, '0);

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_before) do_reset();
            m_cyc_i = vecs[i].cyc; m_stb_i = vecs[i].stb; m_we_i = vecs[i].we;
            m_adr_i = {16'h0, vecs[i].a1, vecs[i].a0};
            m_dat_i = {64'h0, vecs[i].d1, vecs[i].d0};
            m_sel_i = {8'h0, vecs[i].s1, vecs[i].s0};
            s_ack_i = vecs[i].s_ack; s_dat_i = vecs[i].s_dat;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant_o, vecs[i].e_grant);
            chk($sformatf("tbl%0d_s_cyc", i), s_cyc_o, vecs[i].e_cyc);
            chk($sformatf("tbl%0d_s_stb", i), s_stb_o, vecs[i].e_stb);
            chk($sformatf("tbl%0d_s_adr", i), s_adr_o, vecs[i].e_adr);
            chk($sformatf("tbl%0d_s_dat", i), s_dat_o, vecs[i].e_wdat);
            chk($sformatf("tbl%0d_s_sel", i), s_sel_o, vecs[i].e_sel);
            chk($sformatf("tbl%0d_ack", i),   m_ack_o, vecs[i].e_ack);
            chk($sformatf("tbl%0d_rdat", i),  m_dat_o, vecs[i].e_rdat);
            model_check();
            @(posedge clk);
            model_update();
            #1;
            $display("vec %0d: grant=%b s_cyc=%b ack=%b", i, grant_o, s_cyc_o, m_ack_o);
        end

        // Fairness: all four request continuously for eight tenures
        do_reset();
        m_cyc_i = '1; m_stb_i = '1;
        seen = '0;
        for (int t = 0; t < 8; t++) begin
            w = 0;
            while (grant_o == '0 && w < 5) begin
                tick();
                w++;
            end
            g = -1;
            for (int k = 0; k < N; k++) if (grant_o[k]) g = k;
            chk("fair_order", g, t % N);
            if (g >= 0) begin
                chk("fair_unique", seen[g], 1'b0);
                seen[g] = 1'b1;
                if (seen == '1) seen = '0;
                s_ack_i = 1'b1;
                tick();
                s_ack_i = 1'b0; m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
                tick();
                chk("fair_gap", grant_o, '0);
                m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
            end
            $display("fair tenure %0d: granted master %0d", t, g);
        end

        // Watchdog: slave silent, masters 2 and 3 requesting
        do_reset();
        m_cyc_i = 4'b1100; m_stb_i = 4'b1100;
        tick();
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (!s_cyc_o) break;
            hi++;
            tick();
        end
        chk("wdog_cycles", hi, TO);
        chk("wdog_err", m_err_o, 4'b0100);
        chk("wdog_s_stb", s_stb_o, 1'b0);
        tick();
        chk("wdog_err_hold", m_err_o, 4'b0100);
        m_stb_i[2] = 1'b0;
        #1;
        chk("wdog_err_drop", m_err_o, '0);
        m_cyc_i[2] = 1'b0;
        tick();
        chk("wdog_release", grant_o, '0);
        tick();
        chk("wdog_next", grant_o, 4'b1000);
        $display("watchdog: %0d strobe cycles before timeout, next grant=%b", hi, grant_o);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        // Asynchronous reset in the middle of a tenure
        do_reset();
        m_cyc_i = 4'b0010; m_stb_i = 4'b0010; s_ack_i = 1'b1;
        tick();
        chk("rst_pre_ack", m_ack_o, 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_s_cyc", s_cyc_o, 1'b0);
        chk("rst_mid_grant", grant_o, '0);
        chk("rst_mid_ack",   m_ack_o, '0);
        model_reset();
        m_cyc_i = '1; m_stb_i = '1; s_ack_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("rst_first_grant", grant_o, 4'b0001);
        $display("reset mid-tenure: first grant after release=%b", grant_o);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        // Abandoned cycle followed by a late slave ack
        do_reset();
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        tick(); tick();
        m_cyc_i = '0; m_stb_i = '0;
        #1;
        chk("abandon_err", m_err_o, '0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("abandon_late_ack", m_ack_o, '0);
        chk("abandon_late_err", m_err_o, '0);
        chk("abandon_grant",    grant_o, '0);
        $display("abandoned cycle: late ack seen as ack=%b err=%b", m_ack_o, m_err_o);
        s_ack_i = 1'b0;
        tick();

        // Randomized traffic checked against the model every cycle
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 4) == 0) m_cyc_i[k] = ~m_cyc_i[k];
                m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 3) != 0);
                m_we_i[k]  = 1'($urandom_range(0, 1));
            end
            m_adr_i = N*AW'($urandom);
            m_sel_i = N*BE'($urandom);
            m_dat_i = {$urandom, $urandom, $urandom, $urandom};
            s_ack_i = ($urandom_range(0, 2) == 0);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_dat_i = $urandom;
            tick();
            if (c % 50 == 0) $display("random cycle %0d: grant=%b ack=%b err=%b", c, grant_o, m_ack_o, m_err_o);
        end
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
